uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..64).
REQ-002 The block SHALL have port HCLK, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port HRESETn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-005 The block SHALL have port baud_div, input, 16, HCLK cycles per bit; values below 4 are treated as 4.
REQ-006 The block SHALL have port rd_en, input, 1, pop-head strobe.
REQ-007 The block SHALL have port clr_err, input, 1, one-cycle clear of the sticky error flags.
REQ-008 The block SHALL have port rd_data, output, 8, FIFO head (first-word-fall-through), valid while empty=0.
REQ-009 The block SHALL have ports empty and full, output, 1 each, FIFO status.
REQ-010 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-011 The block SHALL have ports overrun, frame_err and parity_err, output, 1 each, sticky error flags.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before use; all rx references below mean the synchronized value.
REQ-013 The FSM SHALL use states IDLE, START, DATA, PARITY and STOP, plus a 16-bit bit-timer and a 3-bit bit index.
REQ-014 In IDLE, rx=0 SHALL cause a move to START with timer=baud_div>>1.
REQ-015 In START, when timer=0, rx=0 SHALL cause a move to DATA with timer=baud_div-1 and index 0; rx=1 SHALL return to IDLE as a glitch, with no flag change.
REQ-016 In DATA, rx SHALL be sampled each time timer=0, shifted LSB first, with timer reloaded to baud_div-1; after the 8th sample the FSM SHALL go to PARITY if UART_RX_PARITY_EN is defined, else to STOP.
REQ-017 In STOP, at timer=0, rx=1 SHALL push the byte; rx=0 SHALL discard it and set frame_err. The FSM SHALL then go to IDLE at mid-stop-bit, so the next start edge is detectable.
REQ-018 A push SHALL reach the FIFO one cycle after the stop sample; level, empty and rd_data SHALL update on that same edge.
REQ-019 A push while full with no pop in the same cycle SHALL drop the byte, set overrun, and leave the FIFO contents unchanged.
REQ-020 A push and a pop in the same cycle SHALL both be accepted, including when full, leaving level unchanged.
REQ-021 rd_en while empty SHALL be ignored, with no pointer or level change.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full SHALL be asserted when level=FIFO_DEPTH, and empty when level=0.
REQ-023 clr_err SHALL clear all three sticky flags; an error event in the same cycle SHALL win, leaving that flag set.
REQ-024 A change to baud_div mid-frame SHALL take effect at the next timer reload.

Reset
REQ-025 While HRESETn=0, the FSM SHALL be in IDLE, the synchronizer flops SHALL be 1, and the timer, index, shift register and pointers SHALL be 0.
REQ-026 While HRESETn=0, outputs SHALL be: empty=1, full=0, level=0, overrun=0, frame_err=0, parity_err=0, rd_data=8'h00.
REQ-027 Reset asserted mid-frame SHALL abandon the partial byte; after release, the next full frame SHALL be received normally.

Configuration
REQ-028 With UART_RX_PARITY_EN defined, PARITY state SHALL sample one even-parity bit after the data bits; a mismatch SHALL set parity_err, and the byte SHALL still be pushed if its stop bit is valid.
REQ-029 Without UART_RX_PARITY_EN, there SHALL be no PARITY state, the frame SHALL be 8N1, and parity_err SHALL be tied to 0.

Verification
REQ-030 Scenario: baud_div=16, 10 ns HCLK, send 8N1 0x41 -> empty=0, level=1, rd_data=0x41 within 10 bit times; then rd_en pulse -> empty=1.
REQ-031 Scenario: FIFO_DEPTH=8, send 0x00..0x08 with no reads -> full=1, level=8, overrun=1; reads return 0x00..0x07 in order.
REQ-032 Scenario: frame 0x55 with stop bit 0 -> frame_err=1, level=0; clr_err pulse -> frame_err=0.
REQ-033 Scenario: rx low pulse of 3 cycles with baud_div=16 -> no push, no flags, FSM back in IDLE.
REQ-034 Scenario: HRESETn low during bit 4 of 0xA5, then frame 0x3C -> only 0x3C is received, level=1.
REQ-035 Scenario (UART_RX_PARITY_EN): 0x07 sent with parity bit 0 -> parity_err=1, rd_data=0x07; with parity bit 1 -> parity_err stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a first-word-fall-through FIFO.
// Line is sampled at mid-bit from a 16-bit down-counting bit timer; error flags are sticky until clr_err.
module uart_rx_fifo #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic                          rx,
   input  logic [15:0]                   baud_div,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [7:0]                    rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overrun,
   output logic                          frame_err,
   output logic                          parity_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          push_q, push_d;
   logic          frame_evt;
   logic          rx_meta, rx_sync;
   logic [15:0]   baud_eff, reload;
`ifdef UART_RX_PARITY_EN
   logic          parity_evt;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_d;
   logic          pop, wr_ok, ovr_evt;

   assign baud_eff = (baud_div < 16'd4) ? 16'd4 : baud_div;
   assign reload   = baud_eff - 16'd1;

   // rx synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         timer_q <= 16'd0;
         idx_q   <= 3'd0;
         shreg_q <= 8'h00;
         push_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         push_q  <= push_d;
      end
   end

   // Receive FSM: each non-idle state waits for the timer to expire, then acts on the sampled line
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      push_d    = 1'b0;
      frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_evt = 1'b0;
`endif
      if (state_q != IDLE && timer_q != 16'd0) begin
         timer_d = timer_q - 16'd1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rx_sync) begin
                  state_d = START;
                  timer_d = baud_eff >> 1;
               end
            end
            START: begin
               if (!rx_sync) begin
                  state_d = DATA;
                  timer_d = reload;
                  idx_d   = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            DATA: begin
               shreg_d = {rx_sync, shreg_q[7:1]};
               timer_d = reload;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               parity_evt = (rx_sync != (^shreg_q));
               timer_d    = reload;
               state_d    = STOP;
            end
`endif
            STOP: begin
               if (rx_sync) push_d    = 1'b1;
               else         frame_evt = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // shreg_q is stable in IDLE, so it still holds the byte on the cycle the push lands
   assign pop     = rd_en && !empty;
   assign wr_ok   = push_q && (!full || pop);
   assign ovr_evt = push_q && full && !pop;

   always_comb begin
      level_d = level;
      if (wr_ok && !pop)      level_d = level + LW'(1);
      else if (!wr_ok && pop) level_d = level - LW'(1);
   end

   always_ff @(posedge HCLK) begin
      if (wr_ok) mem[wr_ptr] <= shreg_q;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
         rd_data <= 8'h00;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         level <= level_d;
         empty <= (level_d == '0);
         full  <= (level_d == LW'(FIFO_DEPTH));
         // Registered head: next stored entry, or the incoming byte when it becomes the head
         if (pop && level > LW'(1))       rd_data <= mem[rd_ptr + AW'(1)];
         else if (wr_ok && (empty || pop)) rd_data <= shreg_q;
      end
   end

   // Sticky flags: a same-cycle error event wins over clr_err
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ovr_evt)      overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
         if (frame_evt)    frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)        parity_err <= 1'b0;
      else if (parity_evt) parity_err <= 1'b1;
      else if (clr_err)    parity_err <= 1'b0;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames against a queue-based model.
// Frame length follows UART_RX_PARITY_EN (8N1 or 8E1).
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          rx;
   logic [15:0]   baud_div;
   logic          rd_en;
   logic          clr_err;
   logic [7:0]    rd_data;
   logic          empty;
   logic          full;
   logic [LW-1:0] level;
   logic          overrun;
   logic          frame_err;
   logic          parity_err;

   uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .rx         (rx),
      .baud_div   (baud_div),
      .rd_en      (rd_en),
      .clr_err    (clr_err),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .level      (level),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 HCLK = ~HCLK;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] q[$];
   bit         m_ovr, m_fe, m_pe;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, ".level"},      int'(level),      q.size());
      check({tag, ".empty"},      int'(empty),      int'(q.size() == 0));
      check({tag, ".full"},       int'(full),       int'(q.size() == DEPTH));
      check({tag, ".overrun"},    int'(overrun),    int'(m_ovr));
      check({tag, ".frame_err"},  int'(frame_err),  int'(m_fe));
      check({tag, ".parity_err"}, int'(parity_err), int'(m_pe));
      if (q.size() > 0) check({tag, ".rd_data"}, int'(rd_data), int'(q[0]));
   endtask

   // Model: one completed frame
   task automatic apply_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
      if (!par_ok) m_pe = 1'b1;
      if (stop_ok) begin
         if (q.size() < DEPTH) q.push_back(d);
         else                  m_ovr = 1'b1;
      end else begin
         m_fe = 1'b1;
      end
   endtask

   // mode 1: rd_en on the cycle the byte lands; mode 2: clr_err on the stop-sample cycle
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                             input int mode, input int b, output logic [7:0] popped);
      logic [11:0] bits;
      int          strobe;
      bits    = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
      bits[9]  = (^d) ^ !par_ok;
      bits[10] = stop_ok;
`else
      bits[9]  = stop_ok;
`endif
      strobe = (mode == 1) ? 4 + b / 2 + NB * b : 3 + b / 2 + NB * b;
      popped = 8'h00;
      for (int c = 0; c < (NB + 1) * b; c++) begin
         rx      = bits[c / b];
         rd_en   = (mode == 1) && (c == strobe);
         clr_err = (mode == 2) && (c == strobe);
         if (rd_en) popped = rd_data;
         tick(1);
      end
      rx      = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic do_read(input string tag);
      logic [7:0] exp;
      if (q.size() > 0) begin
         exp = q.pop_front();
         check({tag, ".rd"}, int'(rd_data), int'(exp));
         rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
      end else begin
         rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
         check({tag, ".rd_empty.level"}, int'(level), 0);
         check({tag, ".rd_empty.empty"}, int'(empty), 1);
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_pe  = 1'b0;
   endtask

   initial begin
      logic [7:0] pd, d, x;
      logic [11:0] bits;
      int          raw, b, nrd;
      bit          sok, pok;

      HRESETn = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; baud_div = 16'd16;
      tick(3);
      check_status("reset");
      check("reset.rd_data", int'(rd_data), 0);
      HRESETn = 1'b1;
      tick(2);

      // Single byte at baud 16, checked by the end of its 10th bit time
      send_frame(8'h41, 1'b1, 1'b1, 0, 16, pd);
      apply_frame(8'h41, 1'b1, 1'b1);
      check("s41.empty", int'(empty), 0);
      check("s41.level", int'(level), 1);
      check("s41.rd_data", int'(rd_data), 8'h41);
      do_read("s41");
      check("s41.empty_after", int'(empty), 1);
      do_read("s41");

      // Fill past depth
      for (int i = 0; i <= DEPTH; i++) begin
         send_frame(8'(i), 1'b1, 1'b1, 0, 16, pd);
         apply_frame(8'(i), 1'b1, 1'b1);
         tick(32);
      end
      check_status("fill");
      for (int i = 0; i < DEPTH; i++) do_read("fill");
      check_status("drain");

      // Push and pop on the same edge while full
      pulse_clr();
      for (int i = 0; i < DEPTH; i++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1, 1'b1, 0, 16, pd);
         apply_frame(d, 1'b1, 1'b1);
         tick(32);
      end
      check_status("refill");
      x = 8'($urandom);
      send_frame(x, 1'b1, 1'b1, 1, 16, pd);
      d = q.pop_front();
      check("simul.popped", int'(pd), int'(d));
      apply_frame(x, 1'b1, 1'b1);
      tick(32);
      check_status("simul");
      for (int i = 0; i < DEPTH; i++) do_read("simul");

      // Bad stop bit, then clear
      send_frame(8'h55, 1'b0, 1'b1, 0, 16, pd);
      apply_frame(8'h55, 1'b0, 1'b1);
      tick(32);
      check_status("ferr");
      pulse_clr();
      check_status("ferr_clr");

      // clr_err coinciding with the framing error event
      send_frame(8'h55, 1'b0, 1'b1, 2, 16, pd);
      apply_frame(8'h55, 1'b0, 1'b1);
      tick(32);
      check_status("ferr_vs_clr");
      pulse_clr();

      // Short low glitch, then a normal frame
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(64);
      check_status("glitch");
      send_frame(8'h5A, 1'b1, 1'b1, 0, 16, pd);
      apply_frame(8'h5A, 1'b1, 1'b1);
      tick(32);
      check_status("post_glitch");
      do_read("post_glitch");

      // Reset during bit 4 of 0xA5
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = 8'hA5;
      for (int c = 0; c < 5 * 16 + 8; c++) begin
         rx = bits[c / 16];
         tick(1);
      end
      HRESETn = 1'b0;
      tick(2);
      rx = 1'b1;
      q.delete();
      m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
      check_status("midrst");
      check("midrst.rd_data", int'(rd_data), 0);
      HRESETn = 1'b1;
      tick(4);
      send_frame(8'h3C, 1'b1, 1'b1, 0, 16, pd);
      apply_frame(8'h3C, 1'b1, 1'b1);
      tick(32);
      check_status("after_rst");
      do_read("after_rst");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 0, 16, pd);
      apply_frame(8'h07, 1'b1, 1'b0);
      tick(32);
      check_status("par_bad");
      do_read("par_bad");
      pulse_clr();
      send_frame(8'h07, 1'b1, 1'b1, 0, 16, pd);
      apply_frame(8'h07, 1'b1, 1'b1);
      tick(32);
      check_status("par_ok");
      do_read("par_ok");
`endif

      // Random frames, baud settings (including sub-minimum values) and reads
      for (int n = 0; n < 40; n++) begin
         raw      = $urandom_range(0, 20);
         baud_div = 16'(raw);
         b        = (raw < 4) ? 4 : raw;
         d        = 8'($urandom);
         sok      = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
         pok      = ($urandom_range(0, 3) != 0);
`else
         pok      = 1'b1;
`endif
         send_frame(d, sok, pok, 0, b, pd);
         apply_frame(d, sok, pok);
         tick(2 * b);
         check_status("rnd");
         nrd = $urandom_range(0, 3);
         for (int r = 0; r < nrd; r++) do_read("rnd");
         if ($urandom_range(0, 5) == 0) begin
            pulse_clr();
            check_status("rnd_clr");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
